// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM pipeline register of the MIPS pipeline.
// Resolves conditional branches and jumps from the ALU flags and issues a
// one-cycle fetch redirect. After a redirect, the branch shadow (younger
// IF/ID contents) is squashed. A delay-slot window can be left open first.
// MEM back-pressure (mem_stall) freezes the stage and is forwarded to EX.
// Optional feature macro: EX_MEM_PERF_CNT_EN adds branch/redirect counters.
module ex_mem_stage #(
  parameter int SHADOW     = 2,
  parameter int DELAY_SLOT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_result,
  input  logic        ex_zero,
  input  logic        ex_neg,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_byte,
  input  logic        ex_unsigned,
  input  logic        ex_link,
  input  logic [31:0] ex_pc,
  input  logic [2:0]  ex_branch_type,
  input  logic [31:0] ex_target,
  input  logic        mem_stall,
  output logic        ex_stall,
  output logic        mem_valid,
  output logic [31:0] mem_result,
  output logic [31:0] mem_store_data,
  output logic [4:0]  mem_rd,
  output logic        mem_reg_write,
  output logic        mem_mem_read,
  output logic        mem_mem_write,
  output logic        mem_byte,
  output logic        mem_unsigned,
`ifdef EX_MEM_PERF_CNT_EN
  output logic [31:0] perf_branches,
  output logic [31:0] perf_taken,
`endif
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  // Squash counter must hold the value SHADOW itself.
  localparam int SQ_W = (SHADOW < 1) ? 1 : $clog2(SHADOW + 1);

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BGEZ = 3'd3;
  localparam logic [2:0] BR_BGTZ = 3'd4;
  localparam logic [2:0] BR_BLEZ = 3'd5;
  localparam logic [2:0] BR_BLTZ = 3'd6;
  localparam logic [2:0] BR_JUMP = 3'd7;

  // Branch outcome from the ALU flags. beq/bne see rs-rt; the
  // compare-with-zero branches see rs-0, so neg/zero describe rs directly.
  function automatic logic branch_taken(input logic [2:0] btype,
                                        input logic       zero,
                                        input logic       neg);
    logic taken;
    case (btype)
      BR_NONE: taken = 1'b0;
      BR_BEQ:  taken = zero;
      BR_BNE:  taken = ~zero;
      BR_BGEZ: taken = ~neg;
      BR_BGTZ: taken = ~neg & ~zero;
      BR_BLEZ: taken = neg | zero;
      BR_BLTZ: taken = neg;
      BR_JUMP: taken = 1'b1;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  // Registered state
  logic            mem_valid_q,      mem_valid_d;
  logic [31:0]     mem_result_q,     mem_result_d;
  logic [31:0]     mem_store_data_q, mem_store_data_d;
  logic [4:0]      mem_rd_q,         mem_rd_d;
  logic            mem_reg_write_q,  mem_reg_write_d;
  logic            mem_mem_read_q,   mem_mem_read_d;
  logic            mem_mem_write_q,  mem_mem_write_d;
  logic            mem_byte_q,       mem_byte_d;
  logic            mem_unsigned_q,   mem_unsigned_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [31:0]     redirect_pc_q,    redirect_pc_d;
  logic            keep_cnt_q,       keep_cnt_d;
  logic [SQ_W-1:0] squash_cnt_q,     squash_cnt_d;

  // Decode of the current EX instruction against the squash state
  logic accept_s;
  logic in_slot_s;
  logic squash_s;
  logic pass_s;
  logic taken_s;
  logic redirect_s;

  assign ex_stall   = mem_stall;
  assign accept_s   = ex_valid & ~mem_stall;
  assign in_slot_s  = (keep_cnt_q != 1'b0);
  // Delay-slot instructions are never squashed, even with squash_cnt pending.
  assign squash_s   = accept_s & ~in_slot_s & (squash_cnt_q != {SQ_W{1'b0}});
  assign pass_s     = accept_s & ~squash_s;
  assign taken_s    = branch_taken(ex_branch_type, ex_zero, ex_neg);
  // A branch sitting in the delay slot is allowed to complete but not redirect.
  assign redirect_s = pass_s & ~in_slot_s & taken_s;

  // Next-state for the MEM-facing registers, redirect pulse and squash counters
  always_comb begin
    mem_valid_d      = mem_valid_q;
    mem_result_d     = mem_result_q;
    mem_store_data_d = mem_store_data_q;
    mem_rd_d         = mem_rd_q;
    mem_reg_write_d  = mem_reg_write_q;
    mem_mem_read_d   = mem_mem_read_q;
    mem_mem_write_d  = mem_mem_write_q;
    mem_byte_d       = mem_byte_q;
    mem_unsigned_d   = mem_unsigned_q;
    redirect_pc_d    = redirect_pc_q;
    keep_cnt_d       = keep_cnt_q;
    squash_cnt_d     = squash_cnt_q;
    // Pulse: cleared on every edge, stall or not.
    redirect_valid_d = 1'b0;

    if (!mem_stall) begin
      // Data fields are loaded every free cycle; only pass_s makes them live.
      mem_valid_d      = pass_s;
      mem_result_d     = ex_link ? (ex_pc + 32'd8) : ex_result;
      mem_store_data_d = ex_store_data;
      mem_rd_d         = ex_rd;
      mem_reg_write_d  = ex_reg_write & pass_s;
      mem_mem_read_d   = ex_mem_read  & pass_s;
      mem_mem_write_d  = ex_mem_write & pass_s;
      mem_byte_d       = ex_byte;
      mem_unsigned_d   = ex_unsigned;
    end else begin
      mem_valid_d = mem_valid_q;
    end

    if (redirect_s) begin
      redirect_valid_d = 1'b1;
      redirect_pc_d    = ex_target;
      keep_cnt_d       = 1'(DELAY_SLOT);
      squash_cnt_d     = SQ_W'(SHADOW);
    end else if (accept_s && in_slot_s) begin
      keep_cnt_d = 1'b0;
    end else if (squash_s) begin
      squash_cnt_d = squash_cnt_q - SQ_W'(1);
    end else begin
      keep_cnt_d   = keep_cnt_q;
      squash_cnt_d = squash_cnt_q;
    end
  end

  // Pipeline register with asynchronous reset; reset also aborts a pending squash
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid_q      <= 1'b0;
      mem_result_q     <= 32'd0;
      mem_store_data_q <= 32'd0;
      mem_rd_q         <= 5'd0;
      mem_reg_write_q  <= 1'b0;
      mem_mem_read_q   <= 1'b0;
      mem_mem_write_q  <= 1'b0;
      mem_byte_q       <= 1'b0;
      mem_unsigned_q   <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
      keep_cnt_q       <= 1'b0;
      squash_cnt_q     <= {SQ_W{1'b0}};
    end else begin
      mem_valid_q      <= mem_valid_d;
      mem_result_q     <= mem_result_d;
      mem_store_data_q <= mem_store_data_d;
      mem_rd_q         <= mem_rd_d;
      mem_reg_write_q  <= mem_reg_write_d;
      mem_mem_read_q   <= mem_mem_read_d;
      mem_mem_write_q  <= mem_mem_write_d;
      mem_byte_q       <= mem_byte_d;
      mem_unsigned_q   <= mem_unsigned_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      keep_cnt_q       <= keep_cnt_d;
      squash_cnt_q     <= squash_cnt_d;
    end
  end

  assign mem_valid      = mem_valid_q;
  assign mem_result     = mem_result_q;
  assign mem_store_data = mem_store_data_q;
  assign mem_rd         = mem_rd_q;
  assign mem_reg_write  = mem_reg_write_q;
  assign mem_mem_read   = mem_mem_read_q;
  assign mem_mem_write  = mem_mem_write_q;
  assign mem_byte       = mem_byte_q;
  assign mem_unsigned   = mem_unsigned_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0] perf_branches_q, perf_branches_d;
  logic [31:0] perf_taken_q,    perf_taken_d;

  // Performance counters: live branches seen and redirects issued (wrap at 2^32)
  always_comb begin
    perf_branches_d = perf_branches_q;
    perf_taken_d    = perf_taken_q;
    if (pass_s && (ex_branch_type != BR_NONE)) begin
      perf_branches_d = perf_branches_q + 32'd1;
    end else begin
      perf_branches_d = perf_branches_q;
    end
    if (redirect_s) begin
      perf_taken_d = perf_taken_q + 32'd1;
    end else begin
      perf_taken_d = perf_taken_q;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branches_q <= 32'd0;
      perf_taken_q    <= 32'd0;
    end else begin
      perf_branches_q <= perf_branches_d;
      perf_taken_q    <= perf_taken_d;
    end
  end

  assign perf_branches = perf_branches_q;
  assign perf_taken    = perf_taken_q;
`endif

endmodule
